led_band_fc_sequencer: RTL and testbench

LED_BAND_FC_SEQUENCER -- requirements
Module: led_band_fc_sequencer

---
 rtl/led_band_fc_sequencer.sv | 125 ++++++++++++
 tb/tb_led_band_fc_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/led_band_fc_sequencer.sv
// Generates the SCLK/LAT framing for one LED-driver function-control write:
// a write-enable preamble, the 48-bit data shift, then the write-FC latch.
module led_band_fc_sequencer #(
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned FCWRTEN_SCLKS = 15,
  parameter int unsigned DATA_SCLKS    = 48,
  parameter int unsigned WRTFC_SCLKS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       LAT,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FCWRTEN = 2'd1,
    DATA    = 2'd2,
    WRTFC   = 2'd3
  } state_t;

  localparam logic [7:0] HALF_LAST     = 8'(CLK_DIV - 1);
  localparam logic [5:0] FCWRTEN_COUNT = 6'(FCWRTEN_SCLKS);
  localparam logic [5:0] DATA_COUNT    = 6'(DATA_SCLKS);
  localparam logic [5:0] WRTFC_COUNT   = 6'(WRTFC_SCLKS);

  state_t     state_q, state_d;
  logic [7:0] half_cnt_q, half_cnt_d;
  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic       sclk_q, sclk_d;
  logic       lat_q, lat_d;
  logic       done_q, done_d;
  logic [5:0] phase_sclks;
  logic       half_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      half_cnt_q <= 8'd0;
      edge_cnt_q <= 6'd0;
      sclk_q     <= 1'b0;
      lat_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      lat_q      <= lat_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    phase_sclks = 6'd0;
    case (state_q)
      FCWRTEN: phase_sclks = FCWRTEN_COUNT;
      DATA:    phase_sclks = DATA_COUNT;
      WRTFC:   phase_sclks = WRTFC_COUNT;
      default: phase_sclks = 6'd0;
    endcase
  end

  assign half_end = (half_cnt_q == HALF_LAST);

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    lat_d      = lat_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      half_cnt_d = 8'd0;
      edge_cnt_d = 6'd0;
      sclk_d     = 1'b0;
      lat_d      = 1'b0;
      if (start) begin
        state_d = FCWRTEN;
        lat_d   = 1'b1;
      end
    end else if (!half_end) begin
      half_cnt_d = half_cnt_q + 8'd1;
    end else begin
      half_cnt_d = 8'd0;
      if (!sclk_q) begin
        sclk_d     = 1'b1;
        edge_cnt_d = edge_cnt_q + 6'd1;
      end else begin
        sclk_d = 1'b0;
        // Phase boundaries only fall at the end of a high half, so LAT moves with SCLK low.
        if (edge_cnt_q == phase_sclks) begin
          edge_cnt_d = 6'd0;
          case (state_q)
            FCWRTEN: begin
              state_d = DATA;
              lat_d   = 1'b0;
            end
            DATA: begin
              state_d = WRTFC;
              lat_d   = 1'b1;
            end
            default: begin
              state_d = IDLE;
              lat_d   = 1'b0;
              done_d  = 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign SCLK  = sclk_q;
  assign LAT   = lat_q;
  assign phase = state_q;

endmodule

// File: tb/tb_led_band_fc_sequencer.sv
// Directed bench: default-divider and CLK_DIV=1 sequencers checked cycle by cycle
// against the expected LAT/SCLK/busy/done/phase timeline.
module tb_led_band_fc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic       busy_a, done_a, sclk_a, lat_a;
  logic       busy_b, done_b, sclk_b, lat_b;
  logic [1:0] phase_a, phase_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_band_fc_sequencer dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a),
    .busy  (busy_a),
    .done  (done_a),
    .SCLK  (sclk_a),
    .LAT   (lat_a),
    .phase (phase_a)
  );

  led_band_fc_sequencer #(.CLK_DIV(1)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b),
    .busy  (busy_b),
    .done  (done_b),
    .SCLK  (sclk_b),
    .LAT   (lat_b),
    .phase (phase_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {SCLK, LAT, busy, done, phase} of the selected instance.
  function automatic logic [5:0] outs(input bit fast);
    if (fast) return {sclk_b, lat_b, busy_b, done_b, phase_b};
    return {sclk_a, lat_a, busy_a, done_a, phase_a};
  endfunction

  // One start pulse, then every cycle compared against the timeline built from
  // the phase lengths; poke re-asserts start mid-sequence, which must be ignored.
  task automatic run_seq(input bit fast, input bit poke, input string name);
    int h, e1, e2, e3, fin;
    int pos_total, pos_lat, bad_edges;
    logic ps, pl;
    logic [5:0] o, e;
    logic       es, el;
    logic [1:0] ep;
    h   = fast ? 1 : 2;
    e1  = 15 * 2 * h;
    e2  = e1 + 48 * 2 * h;
    e3  = e2 + 5 * 2 * h;
    fin = e3 + 1;
    pos_total = 0; pos_lat = 0; bad_edges = 0;
    @(negedge clk);
    if (fast) start_b = 1'b1; else start_a = 1'b1;
    check($sformatf("%s_c0", name), 16'(outs(fast)), 16'h0);
    ps = 1'b0; pl = 1'b0;
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      if (k == 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (poke && k == 100) begin if (fast) start_b = 1'b1; else start_a = 1'b1; end
      if (poke && k == 101) begin start_a = 1'b0; start_b = 1'b0; end
      o  = outs(fast);
      el = (k <= e1) || (k > e2 && k <= e3);
      es = (k <= e3) && (((k - 1) % (2 * h)) >= h);
      ep = (k <= e1) ? 2'd1 : (k <= e2) ? 2'd2 : (k <= e3) ? 2'd3 : 2'd0;
      e  = {es, el, (k <= e3), (k == fin), ep};
      check($sformatf("%s_c%0d", name, k), 16'(o), 16'(e));
      if (o[5] && !ps) begin
        pos_total++;
        if (o[4]) pos_lat++;
        if (o[4] != pl) bad_edges++;
      end
      ps = o[5];
      pl = o[4];
    end
    check($sformatf("%s_posedges", name), 16'(pos_total), 16'd68);
    check($sformatf("%s_posedges_lat_high", name), 16'(pos_lat), 16'd20);
    check($sformatf("%s_posedge_on_lat_change", name), 16'(bad_edges), 16'd0);
  endtask

  initial begin
    int dones;
    logic [5:0] o;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", 16'(outs(1'b0)), 16'h0);
    check("reset_b", 16'(outs(1'b1)), 16'h0);

    // Reset must win over a simultaneous start.
    start_a = 1'b1;
    @(negedge clk);
    check("rst_priority", 16'(outs(1'b0)), 16'h0);
    rst = 1'b0; start_a = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_quiet", 16'(outs(1'b0)), 16'h0);

    run_seq(1'b0, 1'b0, "seq");
    repeat (3) @(negedge clk);
    check("idle_after_seq", 16'(outs(1'b0)), 16'h0);

    run_seq(1'b0, 1'b1, "busy_start");

    // Abort mid-sequence: reset sampled at the end of cycle 100.
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_c101", 16'(outs(1'b0)), 16'h0);
    dones = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("abort_no_done", 16'(dones), 16'd0);
    run_seq(1'b0, 1'b0, "after_abort");

    // start held through two sequences, released in the second done cycle.
    @(negedge clk);
    start_a = 1'b1;
    check("held_c0_busy", 16'(busy_a), 16'd0);
    for (int k = 1; k <= 548; k++) begin
      @(negedge clk);
      if (k == 546) start_a = 1'b0;
      o = outs(1'b0);
      check($sformatf("held_c%0d", k), 16'({o[3], o[2]}),
            16'({(k != 273 && k < 546), (k == 273 || k == 546)}));
    end

    run_seq(1'b1, 1'b0, "div1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
